// File: rtl/ledger_reader_pkg.sv
// Shared constants for the ledger readout path: player count, balance and BCD
// widths, and the readout FSM encoding. Imported by the ledger reader and its
// BCD converter; also intended for reuse by memory_control and money_display.
package ledger_reader_pkg;

    localparam int unsigned NumPlayersDef = 6;
    localparam int unsigned BalW          = 8;
    localparam int unsigned BcdW          = 12;
    localparam int unsigned PlayerW       = 3;
    localparam int unsigned WordW         = NumPlayersDef * BalW;
    // One shift-add-3 step per balance bit.
    localparam int unsigned BcdSteps      = BalW;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
        StConvert,
        StPresent,
        StDone
    } state_e;

endpackage

// File: rtl/ledger_reader_bin2bcd_seq.sv
// Sequential shift-add-3 (double dabble) binary-to-BCD converter.
// Ports:
//   clock, resetn  system clock, async active-low reset
//   start_i        load bin_i and begin a conversion (restarts one in flight)
//   bin_i          8-bit binary value
//   bcd_o          last completed result, hundreds in [11:8]; held until the
//                  next conversion completes
//   done_o         high during the final step; bcd_o is valid from the next cycle
module bin2bcd_seq
    import ledger_reader_pkg::*;
(
    input  logic            clock,
    input  logic            resetn,
    input  logic            start_i,
    input  logic [BalW-1:0] bin_i,
    output logic [BcdW-1:0] bcd_o,
    output logic            done_o
);

    localparam int unsigned ShW = BcdW + BalW;

    logic [ShW-1:0]  sh_q;
    logic [ShW-1:0]  adj;
    logic [ShW-1:0]  sh_d;
    logic [2:0]      cnt_q;
    logic            run_q;
    logic [BcdW-1:0] res_q;

    // Bump every BCD digit that is 5 or more by 3, then shift the whole
    // register left by one bit.
    always_comb begin
        adj = sh_q;
        for (int unsigned d = 0; d < 3; d++) begin
            if (adj[BalW + 4*d +: 4] >= 4'd5) begin
                adj[BalW + 4*d +: 4] = adj[BalW + 4*d +: 4] + 4'd3;
            end
        end
        sh_d = {adj[ShW-2:0], 1'b0};
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sh_q  <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
            res_q <= '0;
        end else if (start_i) begin
            sh_q  <= {{BcdW{1'b0}}, bin_i};
            cnt_q <= '0;
            run_q <= 1'b1;
        end else if (run_q) begin
            sh_q  <= sh_d;
            cnt_q <= cnt_q + 3'd1;
            if (cnt_q == 3'(BcdSteps - 1)) begin
                run_q <= 1'b0;
                res_q <= sh_d[ShW-1:BalW];
            end
        end
    end

    assign done_o = run_q && (cnt_q == 3'(BcdSteps - 1));
    assign bcd_o  = res_q;

endmodule

// File: rtl/ledger_reader.sv
// Reads one packed ledger word from RAM and streams each player's balance, in
// binary and BCD, over a valid/ready interface.
// Ports:
//   clock, resetn      system clock, async active-low reset
//   start, access_sel  readout request pulse and bank to read (captured at start)
//   mem_result         RAM read data (NUM_PLAYERS balances, player 0 in LSBs)
//   mem_access_type    bank select to RAM; mem_wren is tied low
//   out_valid/ready    record handshake; out_player/out_balance/out_bcd payload
//   busy, done         activity flag and end-of-readout pulse
module ledger_reader
    import ledger_reader_pkg::*;
#(
    parameter int unsigned NUM_PLAYERS = NumPlayersDef,
    parameter int unsigned BAL_W       = BalW,
    parameter int unsigned RAM_LATENCY = 1
) (
    input  logic                         clock,
    input  logic                         resetn,
    input  logic                         start,
    input  logic                         access_sel,
    input  logic [NUM_PLAYERS*BAL_W-1:0] mem_result,
    output logic                         mem_access_type,
    output logic                         mem_wren,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [PlayerW-1:0]           out_player,
    output logic [BAL_W-1:0]             out_balance,
    output logic [BcdW-1:0]              out_bcd,
    output logic                         busy,
    output logic                         done
);

    localparam int unsigned LatW = $clog2(RAM_LATENCY + 1);

    state_e                       state_q, state_d;
    logic                         access_type_q;
    logic [PlayerW-1:0]           player_q;
    logic [LatW-1:0]              lat_cnt_q;
    logic [NUM_PLAYERS*BAL_W-1:0] word_q;
    logic [BAL_W-1:0]             balance_q;
    logic [BAL_W-1:0]             next_balance;
    logic [PlayerW-1:0]           next_player;
    logic                         lat_last;
    logic                         xfer;
    logic                         last_player;
    logic                         bcd_start;
    logic                         bcd_done;

    assign lat_last    = (lat_cnt_q == LatW'(1));
    assign xfer        = (state_q == StPresent) && out_ready;
    assign last_player = (player_q == PlayerW'(NUM_PLAYERS - 1));
    assign next_player = player_q + PlayerW'(1);

    // State register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (start) state_d = StReq;
            StReq:     state_d = StWait;
            StWait:    if (lat_last) state_d = StConvert;
            StConvert: if (bcd_done) state_d = StPresent;
            StPresent: if (out_ready) state_d = last_player ? StDone : StConvert;
            StDone:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // FSM outputs. The converter is kicked on the edge that enters CONVERT so
    // that CONVERT lasts exactly one cycle per conversion step.
    always_comb begin
        out_valid = (state_q == StPresent);
        busy      = (state_q != StIdle);
        done      = (state_q == StDone);
        mem_wren  = 1'b0;
        bcd_start = ((state_q == StWait) && lat_last) || (xfer && !last_player);
    end

    // Balance fed to the converter: on leaving WAIT the word is only being
    // latched this edge, so player 0 comes straight from mem_result.
    always_comb begin
        next_balance = '0;
        if (state_q == StWait) begin
            next_balance = mem_result[BAL_W-1:0];
        end else begin
            for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
                if (PlayerW'(p) == next_player) begin
                    next_balance = word_q[p*BAL_W +: BAL_W];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            access_type_q <= 1'b0;
            player_q      <= '0;
            lat_cnt_q     <= '0;
            word_q        <= '0;
            balance_q     <= '0;
        end else begin
            if ((state_q == StIdle) && start) begin
                access_type_q <= access_sel;
                player_q      <= '0;
            end
            if (state_q == StReq) begin
                lat_cnt_q <= LatW'(RAM_LATENCY);
            end
            if (state_q == StWait) begin
                lat_cnt_q <= lat_cnt_q - LatW'(1);
                if (lat_last) begin
                    word_q <= mem_result;
                end
            end
            if (xfer && !last_player) begin
                player_q <= next_player;
            end
            if (bcd_start) begin
                balance_q <= next_balance;
            end
        end
    end

    bin2bcd_seq u_bin2bcd (
        .clock   (clock),
        .resetn  (resetn),
        .start_i (bcd_start),
        .bin_i   (next_balance),
        .bcd_o   (out_bcd),
        .done_o  (bcd_done)
    );

    assign mem_access_type = access_type_q;
    assign out_player      = player_q;
    assign out_balance     = balance_q;

endmodule
